decoder_req_sequencer: RTL and testbench

- Sequences access to the 7-bit decoder core (`decoder_proj`) and shares it between two requesters, A and B.
- Each request carries one input code. The block arbitrates round-robin and drives the code onto the decoder input.
- It waits a fixed settle time, registers the decoder output and returns it with the requester ID over a valid/ready response channel.
- It sits between the io/host logic and the decoder datapath. It is the only driver of the decoder input.

---
 rtl/decoder_req_sequencer.sv | 89 ++++++++
 tb/tb_decoder_req_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_req_sequencer.sv
// rtl/decoder_req_sequencer.sv - round-robin sequencer sharing one decoder core between two requesters
module decoder_req_sequencer #(
  parameter int IN_W   = 7,
  parameter int OUT_W  = 8,
  parameter int SETTLE = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [IN_W-1:0]  a_code,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [IN_W-1:0]  b_code,
  output logic             b_ready,
  output logic [IN_W-1:0]  dec_in,
  input  logic [OUT_W-1:0] dec_out,
  output logic             resp_valid,
  output logic [OUT_W-1:0] resp_data,
  output logic             resp_id,
  input  logic             resp_ready,
  output logic             busy,
  output logic [15:0]      txn_count
);

  if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
    $error("decoder_req_sequencer: SETTLE must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [7:0] CNT_INIT = 8'(SETTLE - 1);

  state_t     state;
  logic       last_grant;
  logic [7:0] settle_cnt;
  logic       grant_a;
  logic       grant_b;

  // On a tie the requester that did not win last time gets the decoder.
  assign grant_a = a_valid && (!b_valid || last_grant);
  assign grant_b = b_valid && (!a_valid || !last_grant);
  assign a_ready = (state == IDLE) && grant_a;
  assign b_ready = (state == IDLE) && grant_b;
  assign busy    = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dec_in     <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= 1'b0;
      txn_count  <= '0;
      last_grant <= 1'b1;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_a || grant_b) begin
            dec_in     <= grant_b ? b_code : a_code;
            resp_id    <= grant_b;
            last_grant <= grant_b;
            settle_cnt <= CNT_INIT;
            state      <= WAIT;
          end
        end
        WAIT: begin
          // dec_out is only looked at here, once the code has had SETTLE edges to propagate.
          if (settle_cnt == 8'd0) begin
            resp_data  <= dec_out;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            txn_count  <= txn_count + 16'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_req_sequencer.sv
// tb/tb_decoder_req_sequencer.sv - directed bench for decoder_req_sequencer
module tb_decoder_req_sequencer;

  logic       clock;
  logic       reset;
  logic       a_valid, b_valid, a_ready, b_ready;
  logic [6:0] a_code, b_code, dec_in;
  logic [7:0] dec_out, resp_data;
  logic       resp_valid, resp_id, resp_ready, busy;
  logic [15:0] txn_count;
  logic       ovr_en;
  logic [7:0] ovr_val;

  logic       w_a_valid, w_b_valid, w_a_ready, w_b_ready;
  logic [6:0] w_a_code, w_b_code, w_dec_in;
  logic [7:0] w_dec_out, w_resp_data;
  logic       w_resp_valid, w_resp_id, w_resp_ready, w_busy;
  logic [15:0] w_txn_count;

  int total = 0;
  int bad = 0;
  int exp_txn = 0;

  function automatic logic [7:0] dec_f(input logic [6:0] c);
    return {1'b1, c} ^ 8'hA5;
  endfunction

  assign dec_out   = ovr_en ? ovr_val : dec_f(dec_in);
  assign w_dec_out = dec_f(w_dec_in);

  decoder_req_sequencer #(.IN_W(7), .OUT_W(8), .SETTLE(2)) u_dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_code(a_code), .a_ready(a_ready),
    .b_valid(b_valid), .b_code(b_code), .b_ready(b_ready),
    .dec_in(dec_in), .dec_out(dec_out),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_id(resp_id),
    .resp_ready(resp_ready), .busy(busy), .txn_count(txn_count)
  );

  decoder_req_sequencer #(.IN_W(7), .OUT_W(8), .SETTLE(1)) u_wrap (
    .clock(clock), .reset(reset),
    .a_valid(w_a_valid), .a_code(w_a_code), .a_ready(w_a_ready),
    .b_valid(w_b_valid), .b_code(w_b_code), .b_ready(w_b_ready),
    .dec_in(w_dec_in), .dec_out(w_dec_out),
    .resp_valid(w_resp_valid), .resp_data(w_resp_data), .resp_id(w_resp_id),
    .resp_ready(w_resp_ready), .busy(w_busy), .txn_count(w_txn_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Presents a request, waits for the grant and lets the accept edge pass.
  task automatic run_req(input logic av, input logic bv, input logic [6:0] ac,
                         input logic [6:0] bc, output logic got_b, output logic [6:0] code);
    int n;
    a_valid = av; b_valid = bv; a_code = ac; b_code = bc;
    #1;
    n = 0;
    while (!(a_ready || b_ready) && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 20) chk("req_timeout", 0, 1);
    chk("one_ready", 32'(a_ready && b_ready), 0);
    got_b = b_ready;
    code  = b_ready ? bc : ac;
    @(posedge clock); #1;
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 20) chk("resp_timeout", 0, 1);
  endtask

  initial begin
    logic       gb;
    logic [6:0] code;
    logic [7:0] exp_d;
    int         hs, cyc;
    logic       hs_next;

    reset = 1'b1; ovr_en = 1'b0; ovr_val = 8'h00;
    a_valid = 0; b_valid = 0; a_code = 0; b_code = 0; resp_ready = 0;
    w_a_valid = 0; w_b_valid = 0; w_a_code = 0; w_b_code = 0; w_resp_ready = 0;
    #2;
    chk("rst_dec_in", dec_in, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_txn", txn_count, 0);
    chk("rst_busy", busy, 0);
    #20 reset = 1'b0;

    // single A request, SETTLE=2, forced decoder value 3C
    @(posedge clock); #1;
    ovr_en = 1'b1; ovr_val = 8'h3C;
    a_valid = 1'b1; a_code = 7'b1001111; resp_ready = 1'b1;
    #1;
    chk("t1_a_ready", a_ready, 1);
    chk("t1_b_ready", b_ready, 0);
    @(posedge clock); #1;
    a_valid = 1'b0;
    chk("t1_dec_in", dec_in, 7'b1001111);
    chk("t1_busy", busy, 1);
    chk("t1_a_ready_drop", a_ready, 0);
    chk("t1_valid_e0", resp_valid, 0);
    @(posedge clock); #1;
    chk("t1_valid_e1", resp_valid, 0);
    @(posedge clock); #1;
    chk("t1_valid_e2", resp_valid, 1);
    chk("t1_data", resp_data, 8'h3C);
    chk("t1_id", resp_id, 0);
    chk("t1_txn_pre", txn_count, 0);
    @(posedge clock); #1;
    exp_txn++;
    chk("t1_valid_done", resp_valid, 0);
    chk("t1_txn", txn_count, exp_txn);
    chk("t1_idle", busy, 0);
    ovr_en = 1'b0;

    // B alone, then six ties alternating A,B
    run_req(1'b0, 1'b1, 7'h00, 7'h33, gb, code);
    chk("b_only_grant", gb, 1);
    wait_resp();
    chk("b_only_data", resp_data, dec_f(7'h33));
    @(posedge clock); #1; exp_txn++;
    for (int i = 0; i < 6; i++) begin
      run_req(1'b1, 1'b1, 7'(10 + i), 7'(40 + i), gb, code);
      chk("rr_grant", gb, 32'(i % 2));
      wait_resp();
      chk("rr_id", resp_id, 32'(i % 2));
      chk("rr_data", resp_data, dec_f(code));
      @(posedge clock); #1; exp_txn++;
    end
    chk("rr_txn", txn_count, exp_txn);

    // consumer stall with both requesters still asserting
    resp_ready = 1'b0;
    run_req(1'b1, 1'b1, 7'h5A, 7'h25, gb, code);
    chk("st_grant", gb, 0);
    a_valid = 1'b1; b_valid = 1'b1;
    wait_resp();
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      chk("st_valid", resp_valid, 1);
      chk("st_data", resp_data, dec_f(7'h5A));
      chk("st_id", resp_id, 0);
      chk("st_a_ready", a_ready, 0);
      chk("st_b_ready", b_ready, 0);
      chk("st_dec_in", dec_in, 7'h5A);
      chk("st_busy", busy, 1);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    a_valid = 1'b0; b_valid = 1'b0; exp_txn++;
    chk("st_hs_valid", resp_valid, 0);
    chk("st_hs_idle", busy, 0);
    chk("st_hs_dec_in", dec_in, 7'h5A);
    chk("st_hs_txn", txn_count, exp_txn);

    // decoder output moves after capture
    resp_ready = 1'b0;
    run_req(1'b0, 1'b1, 7'h00, 7'h11, gb, code);
    wait_resp();
    exp_d = dec_f(7'h11);
    chk("cap_data0", resp_data, exp_d);
    ovr_en = 1'b1; ovr_val = ~exp_d;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("cap_hold", resp_data, exp_d);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1; exp_txn++;
    chk("cap_hs", resp_valid, 0);
    chk("cap_txn", txn_count, exp_txn);
    ovr_en = 1'b0;

    // asynchronous reset in the middle of WAIT
    run_req(1'b1, 1'b0, 7'h6B, 7'h00, gb, code);
    chk("rw_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("rw_valid", resp_valid, 0);
    chk("rw_dec_in", dec_in, 0);
    chk("rw_busy0", busy, 0);
    chk("rw_txn", txn_count, 0);
    #2 reset = 1'b0;
    exp_txn = 0;
    @(posedge clock); #1;
    run_req(1'b1, 1'b1, 7'h0F, 7'h70, gb, code);
    chk("rw_tie_a", gb, 0);
    wait_resp();
    chk("rw_data", resp_data, dec_f(7'h0F));
    chk("rw_id", resp_id, 0);
    @(posedge clock); #1; exp_txn++;
    chk("rw_txn1", txn_count, exp_txn);

    // txn_count wrap on the SETTLE=1 instance
    w_b_valid = 1'b1; w_b_code = 7'h2A; w_resp_ready = 1'b1;
    hs = 0; cyc = 0;
    while (hs < 65537 && cyc < 4 * 65537 + 20) begin
      hs_next = w_resp_valid;
      @(posedge clock); #1;
      cyc++;
      if (hs_next) begin
        hs++;
        if (hs == 65536) chk("wrap_zero", w_txn_count, 0);
      end
    end
    w_b_valid = 1'b0;
    chk("wrap_hs", hs, 65537);
    chk("wrap_one", w_txn_count, 1);
    chk("wrap_data", w_resp_data, dec_f(7'h2A));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
